// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the core (master) and the data-memory responder (slave).
// Signal names mirror the core's ALUOutM / WriteDataM / ReadDataM datapath nets.
interface dmem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        AlignErr;

    modport master (
        output MemReq, MemWrite, Addr, WriteData,
        input  ReadData, Stall, Done, AlignErr
    );

    modport slave (
        input  MemReq, MemWrite, Addr, WriteData,
        output ReadData, Stall, Done, AlignErr
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM that answers one load/store per request, LATENCY+1 cycles after acceptance.
// No queue: Stall holds the whole pipeline from acceptance until the response cycle.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int AW    = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               align_q, align_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               access;
    logic [AW-1:0]      acc_addr;
    logic [31:0]        acc_wdata;
    logic               acc_we;
    logic [IDX_W-1:0]   acc_idx;
    logic               wr_en;

    // Only the word index and byte offset matter; the RAM aliases above that.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[31:AW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        access    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        case (state_q)
            IDLE: begin
                if (bus.MemReq) begin
                    addr_d  = bus.Addr[AW-1:0];
                    wdata_d = bus.WriteData;
                    we_d    = bus.MemWrite;
                    if (LATENCY == 0) begin
                        // Zero latency: the access edge is the acceptance edge, so use the live inputs.
                        state_d   = RESP;
                        access    = 1'b1;
                        acc_addr  = bus.Addr[AW-1:0];
                        acc_wdata = bus.WriteData;
                        acc_we    = bus.MemWrite;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_idx = acc_addr[AW-1:2];
        rdata_d = rdata_q;
        done_d  = 1'b0;
        align_d = 1'b0;
        wr_en   = 1'b0;
        if (access) begin
            done_d = 1'b1;
            if (acc_addr[1:0] != 2'b00) begin
                align_d = 1'b1;
                rdata_d = '0;
            end else if (acc_we) begin
                wr_en   = 1'b1;
                rdata_d = '0;
            end else begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            align_q <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            align_q <= align_d;
            if (wr_en) mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.Stall    = (state_q == IDLE && bus.MemReq) || (state_q == WAIT);
    assign bus.ReadData = rdata_q;
    assign bus.Done     = done_q;
    assign bus.AlignErr = align_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance, each with its own expected-response queue.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    typedef struct {
        logic [31:0] rd;
        logic        al;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Response monitors: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst0 && bus0.Done === 1'b1) begin
            if (q0.size() == 0) chk("dut0_spurious_done", 32'(bus0.Done), 32'd0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_rdata", bus0.ReadData, e.rd);
                chk("dut0_align", 32'(bus0.AlignErr), 32'(e.al));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && bus1.Done === 1'b1) begin
            if (q1.size() == 0) chk("dut1_spurious_done", 32'(bus1.Done), 32'd0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_rdata", bus1.ReadData, e.rd);
                chk("dut1_align", 32'(bus1.AlignErr), 32'(e.al));
            end
        end
    end

    // LATENCY=2: Stall high for 3 cycles, Done in the 4th; inputs scrambled after acceptance.
    task automatic acc0(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_al);
        exp_t e;
        @(posedge clk); #1;
        bus0.MemReq = 1'b1; bus0.MemWrite = we; bus0.Addr = a; bus0.WriteData = wd;
        e.rd = exp_rd; e.al = exp_al;
        q0.push_back(e);
        @(negedge clk);
        chk("dut0_stall_t0", 32'(bus0.Stall), 32'd1);
        @(posedge clk); #1;
        bus0.MemReq = 1'b0; bus0.MemWrite = ~we; bus0.Addr = 32'hFFFF_FFFC; bus0.WriteData = 32'hBAD0_BAD0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("dut0_stall_wait", 32'(bus0.Stall), 32'd1);
            chk("dut0_done_early", 32'(bus0.Done), 32'd0);
        end
        @(negedge clk);
        chk("dut0_stall_resp", 32'(bus0.Stall), 32'd0);
        chk("dut0_done_resp", 32'(bus0.Done), 32'd1);
    endtask

    // LATENCY=0: Stall high for exactly one cycle, Done in the next.
    task automatic acc1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_al);
        exp_t e;
        @(posedge clk); #1;
        bus1.MemReq = 1'b1; bus1.MemWrite = we; bus1.Addr = a; bus1.WriteData = wd;
        e.rd = exp_rd; e.al = exp_al;
        q1.push_back(e);
        @(negedge clk);
        chk("dut1_stall_t0", 32'(bus1.Stall), 32'd1);
        chk("dut1_done_t0", 32'(bus1.Done), 32'd0);
        @(posedge clk); #1;
        bus1.MemReq = 1'b0; bus1.Addr = 32'h0000_0FFC;
        @(negedge clk);
        chk("dut1_stall_resp", 32'(bus1.Stall), 32'd0);
        chk("dut1_done_resp", 32'(bus1.Done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.MemReq = 1'b0; bus0.MemWrite = 1'b0; bus0.Addr = '0; bus0.WriteData = '0;
        bus1.MemReq = 1'b0; bus1.MemWrite = 1'b0; bus1.Addr = '0; bus1.WriteData = '0;
        repeat (2) @(posedge clk);
        #1; rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("rst_rdata", bus0.ReadData, 32'h0);
        chk("rst_stall", 32'(bus0.Stall), 32'd0);
        chk("rst_done", 32'(bus0.Done), 32'd0);
        chk("rst_align", 32'(bus0.AlignErr), 32'd0);

        acc0(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);
        acc0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        acc0(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("rdata_hold", bus0.ReadData, 32'hDEAD_BEEF);
        chk("idle_stall", 32'(bus0.Stall), 32'd0);
        chk("done_clears", 32'(bus0.Done), 32'd0);

        acc0(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b0);
        acc0(1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0);

        acc0(1'b1, 32'h0000_0022, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1);
        acc0(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0);

        // Back-to-back: MemReq stays high; second request accepted in the IDLE cycle after RESP.
        begin
            exp_t e;
            @(posedge clk); #1;
            bus0.MemReq = 1'b1; bus0.MemWrite = 1'b0; bus0.Addr = 32'h0000_0010;
            e.rd = 32'hDEAD_BEEF; e.al = 1'b0; q0.push_back(e);
            e.rd = 32'h0000_0000; e.al = 1'b0; q0.push_back(e);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("b2b_stall_a", 32'(bus0.Stall), 32'd1);
            end
            @(negedge clk);
            chk("b2b_resp_a_stall", 32'(bus0.Stall), 32'd0);
            chk("b2b_resp_a_done", 32'(bus0.Done), 32'd1);
            @(posedge clk); #1;
            bus0.Addr = 32'h0000_0014;
            @(negedge clk);
            chk("b2b_idle_stall", 32'(bus0.Stall), 32'd1);
            chk("b2b_idle_done", 32'(bus0.Done), 32'd0);
            @(posedge clk); #1;
            bus0.MemReq = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("b2b_stall_b", 32'(bus0.Stall), 32'd1);
                chk("b2b_done_gap", 32'(bus0.Done), 32'd0);
            end
            @(negedge clk);
            chk("b2b_resp_b_done", 32'(bus0.Done), 32'd1);
            @(negedge clk);
            chk("b2b_no_third", 32'(bus0.Done), 32'd0);
        end

        // Reset during WAIT discards the in-flight store and clears the RAM.
        @(posedge clk); #1;
        bus0.MemReq = 1'b1; bus0.MemWrite = 1'b1; bus0.Addr = 32'h0000_0008; bus0.WriteData = 32'h5555_5555;
        @(posedge clk); #1;
        bus0.MemReq = 1'b0; rst0 = 1'b1;
        @(negedge clk);
        chk("mid_wait_stall", 32'(bus0.Stall), 32'd1);
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(bus0.Stall), 32'd0);
        chk("post_rst_done", 32'(bus0.Done), 32'd0);
        chk("post_rst_rdata", bus0.ReadData, 32'h0);
        acc0(1'b0, 32'h0000_0008, 32'h0, 32'h0000_0000, 1'b0);
        acc0(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0);

        acc1(1'b1, 32'h0000_0008, 32'h5555_5555, 32'h0000_0000, 1'b0);
        acc1(1'b0, 32'h0000_0008, 32'h0, 32'h5555_5555, 1'b0);
        acc1(1'b0, 32'h0000_0009, 32'h0, 32'h0000_0000, 1'b1);
        acc1(1'b0, 32'h0000_0108, 32'h0, 32'h5555_5555, 1'b0);

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
